led_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
- Shares one nibble-to-segment decoder across DIGITS positions: presents one nibble at a time and drives the active-low digit enables.
- Takes new display values through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new digits.
- Adds inter-digit ghost blanking and optional leading-zero suppression.

---
 rtl/led_scan_ctrl.sv | 102 ++++++++++
 tb/tb_led_scan_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed 7-segment scan with frame-synchronous value commit,
// ghost blanking between digits and optional leading-zero suppression.
module led_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  enable,
  input  logic                  lz_suppress,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [3:0]            nibble,
  output logic                  blank,
  output logic [DIGITS-1:0]     _digit,
  output logic                  frame_done
);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic [4*DIGITS-1:0] active, pending;
  logic                pending_full, pending_full_n;
  logic                accept, commit, wrap, suppressed;
  logic [3:0]          nibble_n;
  logic                blank_n;
  logic [DIGITS-1:0]   digit_n;

  assign accept         = value_valid & value_ready;
  assign pending_full_n = accept | (pending_full & ~commit);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      value_ready  <= 1'b1;
      nibble       <= '0;
      blank        <= 1'b1;
      _digit       <= '1;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      active       <= (commit && pending_full) ? pending : active;
      pending      <= accept ? value_in : pending;
      pending_full <= pending_full_n;
      value_ready  <= ~pending_full_n;
      nibble       <= nibble_n;
      blank        <= blank_n;
      _digit       <= digit_n;
      frame_done   <= wrap;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    commit  = 1'b0;
    wrap    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else if (state == IDLE) begin
      state_n = BLANK;
      cnt_n   = '0;
      idx_n   = '0;
      commit  = 1'b1;
    end else if (state == SHOW && cnt == CNT_LAST) begin
      state_n = BLANK;
      cnt_n   = '0;
      wrap    = (idx == IDX_LAST);
      idx_n   = wrap ? '0 : idx + 1'b1;
      commit  = wrap;
    end else if (state == BLANK && cnt == BLANK_LAST) begin
      state_n = SHOW;
    end
  end

  // Outputs are computed from the next state so they change on the same edge as it.
  always_comb begin
    suppressed = lz_suppress && (idx_n != '0) && ((active >> {idx_n, 2'b00}) == '0);
    nibble_n   = (state_n == SHOW) ? active[{idx_n, 2'b00} +: 4] : nibble;
    blank_n    = (state_n != SHOW) || suppressed;
    digit_n    = blank_n ? '1 : ~(DIGITS'(1) << idx_n);
  end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: randomized and directed checks against a time-based frame model.
module tb_led_scan_ctrl;
  localparam int D = 4, V = 8, B = 2, F = D * V;

  logic        clk = 0, rst_n = 0, en = 0, lz = 0, vv = 0;
  logic [15:0] vin = '0;
  logic        value_ready, blank, frame_done;
  logic [3:0]  nibble, dig;

  int tests = 0, fails = 0;

  bit          m_run, m_full;
  int          t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_nib, m_dig;
  logic        m_blank, m_fd;

  led_scan_ctrl #(.DIGITS(D), .DIV(V), .BLANK_CYCLES(B)) dut (
    .clk(clk), ._reset(rst_n), .enable(en), .lz_suppress(lz),
    .value_in(vin), .value_valid(vv), .value_ready(value_ready),
    .nibble(nibble), .blank(blank), ._digit(dig), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_full = 0; t = 0;
    m_act = '0; m_pend = '0; m_nib = '0; m_dig = '1; m_blank = 1; m_fd = 0;
  endtask

  // Model: t counts cycles since the scan (re)started; slot and phase follow by division.
  task automatic tick();
    int phase, d;
    bit acc, commit, sup;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      acc = vv && !m_full;
      m_fd = 0;
      if (!en) begin
        m_run = 0; m_dig = '1; m_blank = 1;
      end else begin
        if (!m_run) begin m_run = 1; t = 0; end else t++;
        commit = (t % F) == 0;
        m_fd = commit && t != 0;
        if (commit && m_full) begin m_act = m_pend; m_full = 0; end
        phase = t % V;
        d = (t / V) % D;
        if (phase >= B) begin
          m_nib = m_act[4*d +: 4];
          sup = lz && d > 0 && (m_act >> (4 * d)) == 0;
          m_dig = sup ? 4'hf : ~(4'b0001 << d);
          m_blank = sup;
        end else begin
          m_dig = '1; m_blank = 1;
        end
      end
      if (acc) begin m_pend = vin; m_full = 1; end
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({dig, blank, nibble, frame_done, value_ready} !== {4'hf, 1'b1, 4'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset got dig=%b blank=%b nib=%h fd=%b rdy=%b", dig, blank, nibble, frame_done, value_ready);
    end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_scan();
    int pulses = 0;
    vv = 1; vin = 16'h1234;
    tick();
    vv = 0;
    tests++;
    if (value_ready !== 1'b0) begin fails++; $display("FAIL scan_accept_ready got %b exp 0", value_ready); end
    en = 1;
    tick();
    tests++;
    if (value_ready !== 1'b1) begin fails++; $display("FAIL scan_commit_ready got %b exp 1", value_ready); end
    repeat (3 * F) begin
      tick();
      pulses += frame_done;
      tests++;
      if ({dig, blank, nibble, frame_done, value_ready} !== {m_dig, m_blank, m_nib, m_fd, ~m_full}) begin
        fails++;
        $display("FAIL scan t=%0d got %b_%b_%h_%b_%b exp %b_%b_%h_%b_%b", t, dig, blank, nibble, frame_done, value_ready, m_dig, m_blank, m_nib, m_fd, ~m_full);
      end
    end
    tests++;
    if (pulses != 3) begin fails++; $display("FAIL scan_frame_done_count got %0d exp 3", pulses); end
  endtask

  task automatic test_midframe();
    repeat (V + B) tick();
    tests++;
    if ({dig, nibble} !== {4'b1101, 4'h3}) begin fails++; $display("FAIL mid_digit1 got %b_%h exp 1101_3", dig, nibble); end
    vv = 1; vin = 16'hABCD;
    tick();
    vv = 0;
    repeat (2 * F) begin
      tick();
      tests++;
      if ({dig, blank, nibble, frame_done, value_ready} !== {m_dig, m_blank, m_nib, m_fd, ~m_full}) begin
        fails++;
        $display("FAIL midframe t=%0d got %b_%b_%h_%b_%b exp %b_%b_%h_%b_%b", t, dig, blank, nibble, frame_done, value_ready, m_dig, m_blank, m_nib, m_fd, ~m_full);
      end
    end
  endtask

  task automatic test_hold_valid();
    vv = 1; vin = 16'h1111;
    tick();
    vin = 16'h5555;
    repeat (2 * F + 5) begin
      tick();
      tests++;
      if ({dig, blank, nibble, frame_done, value_ready} !== {m_dig, m_blank, m_nib, m_fd, ~m_full}) begin
        fails++;
        $display("FAIL hold t=%0d got %b_%b_%h_%b_%b exp %b_%b_%h_%b_%b", t, dig, blank, nibble, frame_done, value_ready, m_dig, m_blank, m_nib, m_fd, ~m_full);
      end
    end
    vv = 0;
    repeat (F) tick();
  endtask

  task automatic test_lz();
    logic [15:0] vals [5];
    vals = '{16'h0070, 16'h0000, 16'h0100, 16'($urandom), 16'($urandom_range(0, 255))};
    lz = 1;
    foreach (vals[k]) begin
      vv = 1; vin = vals[k];
      tick();
      vv = 0;
      repeat (2 * F) begin
        tick();
        tests++;
        if ({dig, blank, nibble, frame_done, value_ready} !== {m_dig, m_blank, m_nib, m_fd, ~m_full}) begin
          fails++;
          $display("FAIL lz v=%h t=%0d got %b_%b_%h_%b_%b exp %b_%b_%h_%b_%b", vals[k], t, dig, blank, nibble, frame_done, value_ready, m_dig, m_blank, m_nib, m_fd, ~m_full);
        end
      end
    end
    lz = 0;
  endtask

  task automatic test_enable_drop();
    int n = 0;
    while (!(m_run && (t / V) % D == 2 && t % V >= B) && n < 2 * F) begin tick(); n++; end
    tests++;
    if (n >= 2 * F) begin fails++; $display("FAIL drop_wait_timeout got %0d exp <%0d", n, 2 * F); end
    en = 0;
    tick();
    tests++;
    if ({dig, blank, frame_done} !== {4'hf, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL drop got dig=%b blank=%b fd=%b exp 1111_1_0", dig, blank, frame_done);
    end
    repeat (3) tick();
    en = 1;
    repeat (F + 4) begin
      tick();
      tests++;
      if ({dig, blank, nibble, frame_done, value_ready} !== {m_dig, m_blank, m_nib, m_fd, ~m_full}) begin
        fails++;
        $display("FAIL restart t=%0d got %b_%b_%h_%b_%b exp %b_%b_%h_%b_%b", t, dig, blank, nibble, frame_done, value_ready, m_dig, m_blank, m_nib, m_fd, ~m_full);
      end
    end
  endtask

  task automatic test_random();
    repeat (3000) begin
      vv  = ($urandom_range(0, 3) == 0);
      vin = 16'($urandom);
      if ($urandom_range(0, 49) == 0) lz = ~lz;
      if ($urandom_range(0, 199) == 0) en = ~en;
      if (!en && $urandom_range(0, 9) == 0) en = 1;
      tick();
      tests++;
      if ({dig, blank, nibble, frame_done, value_ready} !== {m_dig, m_blank, m_nib, m_fd, ~m_full}) begin
        fails++;
        $display("FAIL random t=%0d got %b_%b_%h_%b_%b exp %b_%b_%h_%b_%b", t, dig, blank, nibble, frame_done, value_ready, m_dig, m_blank, m_nib, m_fd, ~m_full);
      end
    end
    vv = 0; en = 1; lz = 0;
  endtask

  task automatic test_async_reset();
    int n = 0;
    while (!(m_run && t % V >= B) && n < 2 * F) begin tick(); n++; end
    #2 rst_n = 0;
    #1;
    tests++;
    if ({dig, blank, nibble, frame_done, value_ready} !== {4'hf, 1'b1, 4'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL async_reset got dig=%b blank=%b nib=%h fd=%b rdy=%b", dig, blank, nibble, frame_done, value_ready);
    end
    model_reset();
    @(negedge clk) rst_n = 1;
    en = 1;
    repeat (B + 1) tick();
    tests++;
    if ({dig, blank, nibble} !== {4'b1110, 1'b0, 4'h0}) begin
      fails++;
      $display("FAIL post_reset_digit0 got %b_%b_%h exp 1110_0_0", dig, blank, nibble);
    end
    repeat (F) begin
      tick();
      tests++;
      if ({dig, blank, nibble, frame_done, value_ready} !== {m_dig, m_blank, m_nib, m_fd, ~m_full}) begin
        fails++;
        $display("FAIL post_reset t=%0d got %b_%b_%h_%b_%b exp %b_%b_%h_%b_%b", t, dig, blank, nibble, frame_done, value_ready, m_dig, m_blank, m_nib, m_fd, ~m_full);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_midframe();
    test_hold_valid();
    test_lz();
    test_enable_drop();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
